// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared constants for the unified instruction/data memory port arbiter:
//   default memory geometry, the NOP returned on fetch faults, RISC-V
//   load/store funct3 codes and the fetch/data phase encodings.
package mem_port_arbiter_pkg;

  localparam int          ADDR_W    = 9;
  localparam int          MEM_BYTES = 512;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

  typedef logic [2:0] funct3_t;

  // Loads and stores share width encodings; the we bit tells them apart.
  localparam funct3_t F3_LB  = 3'b000;
  localparam funct3_t F3_LH  = 3'b001;
  localparam funct3_t F3_LW  = 3'b010;
  localparam funct3_t F3_LBU = 3'b100;
  localparam funct3_t F3_LHU = 3'b101;
  localparam funct3_t F3_SB  = 3'b000;
  localparam funct3_t F3_SH  = 3'b001;
  localparam funct3_t F3_SW  = 3'b010;

  localparam logic [0:0] PH_FETCH = 1'b0;
  localparam logic [0:0] PH_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Data request/response handshake between the pipeline (master) and the
//   memory port arbiter (slave).
//   dreq_valid/ready, dreq_we, dreq_addr, dreq_funct3, dreq_wdata : request
//   dresp_valid, dresp_rdata, dresp_fault                        : response
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic        dreq_valid;
  logic        dreq_ready;
  logic        dreq_we;
  logic [31:0] dreq_addr;
  funct3_t     dreq_funct3;
  logic [31:0] dreq_wdata;
  logic        dresp_valid;
  logic [31:0] dresp_rdata;
  logic        dresp_fault;

  modport master (
    output dreq_valid, dreq_we, dreq_addr, dreq_funct3, dreq_wdata,
    input  dreq_ready, dresp_valid, dresp_rdata, dresp_fault
  );

  modport slave (
    input  dreq_valid, dreq_we, dreq_addr, dreq_funct3, dreq_wdata,
    output dreq_ready, dresp_valid, dresp_rdata, dresp_fault
  );

endinterface

// File: rtl/mem_port_arbiter_checker.sv
// mem_access_checker
//   Combinational legality check for one memory access.
//   funct3, addr, we : access description (we=1 store, we=0 load)
//   fault            : undefined funct3, misaligned, or beyond memory
//   size             : access size in bytes (1, 2 or 4)
module mem_access_checker #(
  parameter int ADDR_W    = mem_port_arbiter_pkg::ADDR_W,
  parameter int MEM_BYTES = mem_port_arbiter_pkg::MEM_BYTES
) (
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic        we,
  output logic        fault,
  output logic [2:0]  size
);
  import mem_port_arbiter_pkg::*;

  logic        legal;
  logic        misalign;
  logic        out_of_range;
  logic [32:0] end_addr;

  always_comb begin
    size  = 3'd4;
    legal = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB:   begin size = 3'd1; legal = 1'b1; end
        F3_SH:   begin size = 3'd2; legal = 1'b1; end
        F3_SW:   begin size = 3'd4; legal = 1'b1; end
        default: begin size = 3'd4; legal = 1'b0; end
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: begin size = 3'd1; legal = 1'b1; end
        F3_LH, F3_LHU: begin size = 3'd2; legal = 1'b1; end
        F3_LW:         begin size = 3'd4; legal = 1'b1; end
        default:       begin size = 3'd4; legal = 1'b0; end
      endcase
    end

    misalign = ((size == 3'd2) && addr[0]) ||
               ((size == 3'd4) && (addr[1:0] != 2'b00));

    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    end_addr     = {1'b0, addr} + 33'(size) - 33'd1;
    out_of_range = (addr[31:ADDR_W] != '0) || (end_addr >= 33'(MEM_BYTES));

    fault = !legal || misalign || out_of_range;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Time-multiplexes the single-port byte memory between instruction fetch
//   and data load/store. The phase output doubles as the memory clk_slow.
//   clk, rst                     : clock, async active-low reset
//   pc, if_hold                  : fetch address, fetch capture freeze
//   dbus                         : data request/response handshake (slave)
//   instr_q/valid/fault          : captured instruction and status
//   fetch_phase                  : 1 during the fetch phase
//   mem_addr/read/write/funct3/wdata, mem_rdata, mem_inst : memory side
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   PH_FETCH | port addresses pc; instruction captured on closing edge
//   PH_DATA  | port serves a pending data request; response next cycle
module mem_port_arbiter #(
  parameter int          ADDR_W    = mem_port_arbiter_pkg::ADDR_W,
  parameter int          MEM_BYTES = mem_port_arbiter_pkg::MEM_BYTES,
  parameter logic [31:0] NOP_INSTR = mem_port_arbiter_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   dbus,
  input  logic [31:0]         pc,
  input  logic                if_hold,
  output logic [31:0]         instr_q,
  output logic                instr_valid,
  output logic                instr_fault,
  output logic                fetch_phase,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_read,
  output logic                mem_write,
  output logic [2:0]          mem_funct3,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic [31:0]         mem_inst
);
  import mem_port_arbiter_pkg::*;

  logic [0:0] state;
  logic       fetch_fault;
  logic [2:0] fetch_size;
  logic       data_fault;
  logic [2:0] data_size;
  logic       accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PH_FETCH;
    end else begin
      state <= (state == PH_FETCH) ? PH_DATA : PH_FETCH;
    end
  end

  assign fetch_phase     = (state == PH_FETCH);
  assign dbus.dreq_ready = (state == PH_DATA);
  assign accept          = dbus.dreq_valid && dbus.dreq_ready;

  // Instruction fetch is checked as a word load at pc.
  mem_access_checker #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_fetch_chk (
    .funct3 (F3_LW),
    .addr   (pc),
    .we     (1'b0),
    .fault  (fetch_fault),
    .size   (fetch_size)
  );

  mem_access_checker #(
    .ADDR_W    (ADDR_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_data_chk (
    .funct3 (dbus.dreq_funct3),
    .addr   (dbus.dreq_addr),
    .we     (dbus.dreq_we),
    .fault  (data_fault),
    .size   (data_size)
  );

  // Strobes derive from the async-reset state register, so asserting rst
  // drops mem_write immediately and aborts a store in flight.
  always_comb begin
    mem_addr   = pc[ADDR_W-1:0];
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = F3_LW;
    mem_wdata  = '0;
    if (state == PH_DATA) begin
      mem_addr   = dbus.dreq_addr[ADDR_W-1:0];
      mem_funct3 = dbus.dreq_funct3;
      mem_wdata  = dbus.dreq_wdata;
      if (accept && !data_fault) begin
        mem_read  = !dbus.dreq_we;
        mem_write = dbus.dreq_we;
      end
    end
  end

  // instr_fault describes the instruction currently held in instr_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q     <= NOP_INSTR;
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
    end else if ((state == PH_FETCH) && !if_hold) begin
      instr_valid <= 1'b1;
      if (fetch_fault) begin
        instr_q     <= NOP_INSTR;
        instr_fault <= 1'b1;
      end else begin
        instr_q     <= mem_inst;
        instr_fault <= 1'b0;
      end
    end else begin
      instr_valid <= 1'b0;
    end
  end

  // Response data/fault hold their last values between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbus.dresp_valid <= 1'b0;
      dbus.dresp_rdata <= '0;
      dbus.dresp_fault <= 1'b0;
    end else begin
      dbus.dresp_valid <= accept;
      if (accept) begin
        dbus.dresp_fault <= data_fault;
        dbus.dresp_rdata <= (!dbus.dreq_we && !data_fault) ? mem_rdata : 32'h0;
      end
    end
  end

  a_fetch_size : assert property (@(posedge clk) disable iff (!rst)
    fetch_size == 3'd4);

  a_data_size : assert property (@(posedge clk) disable iff (!rst)
    (accept && !data_fault) |-> (data_size inside {3'd1, 3'd2, 3'd4}));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the unified single-port byte memory (512 B).
- Time-multiplexes one port between instruction fetch and data load/store by generating the fetch/data phase signal that the memory uses as clk_slow.
- Checks alignment and range, captures fetched instructions and load data into registers, and gives the pipeline a valid/ready data handshake.

Parameters:
ADDR_W, 9, memory address width (byte address)
MEM_BYTES, 512, memory size in bytes; any access with addr+size-1 >= MEM_BYTES faults
NOP_INSTR, 32'h00000033, instruction value held in instr_q after reset and on fetch fault

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
pc  in  32  fetch address
if_hold  in  1  freeze fetch capture (IF stall)
dreq_valid  in  1  data request valid
dreq_ready  out  1  request accepted this cycle
dreq_we  in  1  1 = store, 0 = load
dreq_addr  in  32  data byte address
dreq_funct3  in  3  RISC-V load/store funct3
dreq_wdata  in  32  store data (rs2)
dresp_valid  out  1  one-cycle pulse: response available
dresp_rdata  out  32  load result (0 for stores/faults)
dresp_fault  out  1  misaligned or out-of-range data access
instr_q  out  32  last captured instruction
instr_valid  out  1  instr_q updated this cycle
instr_fault  out  1  fetch misaligned/out of range
fetch_phase  out  1  to memory clk_slow; 1 = fetch phase
mem_addr  out  ADDR_W  to memory addr
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite
mem_funct3  out  3  to memory funct3
mem_wdata  out  32  to memory data_in
mem_rdata  in  32  from memory data_out
mem_inst  in  32  from memory inst_out

Behaviour:
- Reset (rst=0, async): phase=FETCH, instr_q=NOP_INSTR, and all of instr_valid, instr_fault, dresp_valid, dresp_rdata and dresp_fault = 0.
- Reset forces mem_read=mem_write=0 immediately, so a store in flight is aborted and no memory byte changes.
- Two-state FSM: FETCH -> DATA -> FETCH, toggling every clk after reset is released. fetch_phase = (state==FETCH).
- FETCH cycle:
  - mem_addr = pc[ADDR_W-1:0]; mem_read = mem_write = 0; dreq_ready = 0.
  - On the closing posedge, if !if_hold:
    - If pc[1:0]==0 and pc+3 < MEM_BYTES: instr_q <= mem_inst.
    - Otherwise: instr_q <= NOP_INSTR and instr_fault <= 1.
    - instr_valid <= 1.
  - If if_hold=1: instr_q is unchanged and instr_valid <= 0.
- DATA cycle:
  - dreq_ready = 1 (combinational, depends only on state).
  - Accept occurs when dreq_valid && dreq_ready.
  - fault = LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, or addr+size-1 >= MEM_BYTES, or dreq_addr[31:ADDR_W]!=0, or undefined funct3.
  - If accepted and !fault: mem_addr = dreq_addr[ADDR_W-1:0], mem_funct3 = dreq_funct3, mem_wdata = dreq_wdata, mem_read = !dreq_we, mem_write = dreq_we.
  - If fault or no accept: mem_read = mem_write = 0.
  - Closing posedge after an accept: dresp_valid <= 1, dresp_fault <= fault, dresp_rdata <= (load && !fault) ? mem_rdata : 0.
- All pulse outputs (dresp_valid, instr_valid) are high for exactly one cycle and otherwise 0.
- The requester holds its request stable until it sees dreq_ready.
- Worst-case latency from request to response is 3 cycles: 1 cycle waiting in FETCH, 1 accept cycle in DATA, then the response cycle.
- The DATA cycle is idle when no request is pending; the phase still toggles, so fetch cadence is fixed at 1 instruction per 2 clk.
- Simultaneous if_hold and a data request are independent and both handled.
- pc wrap past MEM_BYTES is reported via instr_fault; no wrap-around is performed.

Decomposition:
- Shared package (defines): F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW; NOP_INSTR; phase encodings PH_FETCH/PH_DATA.
- One natural sub-module: mem_access_checker. It is combinational: inputs funct3, addr, we; outputs fault and size. It is reused for both the fetch check (as an LW) and the data check.

Test Plan:
1. Reset release with pc=0 and mem[3:0]=32'h00000033: fetch_phase toggles 1,0,1; after the first FETCH, instr_q=32'h00000033 and instr_valid pulses.
2. SW 32'hDEADBEEF at 0x80, then LW 0x80: mem_write is high only in DATA; dresp_valid follows; the load returns 32'hDEADBEEF with dresp_fault=0.
3. LH at 0x81: dresp_fault=1, dresp_rdata=0, mem_read never asserted. SW at 0x1FE (out of range): fault, mem_write=0.
4. Request raised during FETCH: dreq_ready=0 that cycle, accepted in the next (DATA) cycle, dresp_valid the cycle after.
5. if_hold=1 for 4 clk with pc changing: instr_q stays fixed and instr_valid=0. Release with pc=0x2: instr_q=NOP, instr_fault=1.
6. Assert rst mid-DATA during an SB to 0x40: mem_write drops asynchronously, mem[0x40] is unchanged, and all outputs return to their reset values.
